// File: rtl/spi_burst_interface.sv
// SPI mode-0 slave owning a DEPTH-byte configuration memory with 16-bit burst
// addressing, a status byte with sticky error and a small ready-flag register.
module spi_burst_interface #(
   parameter int unsigned DEPTH     = 80,
   parameter int unsigned NUM_FLAGS = 3
) (
   input  logic                   SCLK,
   input  logic                   RESET,
   input  logic                   SS,
   input  logic                   MOSI,
   output logic                   MISO,
   output logic [DEPTH*8-1:0]     all_data_out,
   output logic [NUM_FLAGS-1:0]   flags_out,
   output logic                   wr_pulse,
   output logic                   busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_WRITE,
      S_READ,
      S_STATUS,
      S_FLAGS,
      S_DONE
   } state_t;

   localparam logic [7:0]  OP_WRITE    = 8'h02;
   localparam logic [7:0]  OP_READ     = 8'h03;
   localparam logic [7:0]  OP_STATUS   = 8'h05;
   localparam logic [7:0]  OP_SETFLAGS = 8'h06;
   localparam logic [15:0] ADDR_LAST   = 16'(DEPTH - 1);

   state_t                 state, state_nxt;
   logic [2:0]             bit_cnt;
   logic [7:0]             rx_sr;
   logic [7:0]             tx_sr, tx_nxt;
   logic [15:0]            addr, addr_nxt;
   logic                   is_read, is_read_nxt;
   logic                   err, err_nxt;
   logic [NUM_FLAGS-1:0]   flags_nxt;
   logic                   mem_we;
   logic [7:0]             mem [DEPTH];

   logic                   byte_done;
   logic [7:0]             rx_byte;
   logic [15:0]            addr_inc;
   logic [15:0]            rd_addr;
   logic [7:0]             rd_byte;
   logic                   wr_in_range;

   always_comb begin
      rx_byte     = {rx_sr[6:0], MOSI};
      byte_done   = (bit_cnt == 3'd7);
      addr_inc    = (addr == ADDR_LAST) ? 16'd0 : addr + 16'd1;
      wr_in_range = (32'(addr) < DEPTH);
      // The ADDR_L edge reads at the freshly assembled address; a running burst reads ahead.
      rd_addr     = (state == S_ADDR_L) ? {addr[15:8], rx_byte} : addr_inc;
   end

   always_comb begin
      rd_byte = 8'h00;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (rd_addr == 16'(k)) rd_byte = mem[k];
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      addr_nxt    = addr;
      is_read_nxt = is_read;
      err_nxt     = err;
      flags_nxt   = flags_out;
      tx_nxt      = {tx_sr[6:0], 1'b0};
      mem_we      = 1'b0;

      if (SS) begin
         state_nxt = S_IDLE;
         tx_nxt    = 8'h00;
      end else if (byte_done) begin
         unique case (state)
            S_IDLE: begin
               case (rx_byte)
                  OP_WRITE: begin
                     state_nxt   = S_ADDR_H;
                     is_read_nxt = 1'b0;
                  end
                  OP_READ: begin
                     state_nxt   = S_ADDR_H;
                     is_read_nxt = 1'b1;
                  end
                  OP_STATUS: begin
                     state_nxt = S_STATUS;
                     tx_nxt    = {err, 7'(flags_out)};
                  end
                  OP_SETFLAGS: state_nxt = S_FLAGS;
                  default: begin
                     err_nxt   = 1'b1;
                     state_nxt = S_DONE;
                  end
               endcase
            end
            S_ADDR_H: begin
               addr_nxt  = {rx_byte, addr[7:0]};
               state_nxt = S_ADDR_L;
            end
            S_ADDR_L: begin
               addr_nxt = {addr[15:8], rx_byte};
               if (is_read) begin
                  tx_nxt    = rd_byte;
                  state_nxt = S_READ;
               end else begin
                  state_nxt = S_WRITE;
               end
            end
            S_WRITE: begin
               mem_we   = wr_in_range;
               addr_nxt = addr_inc;
            end
            S_READ: begin
               addr_nxt = addr_inc;
               tx_nxt   = rd_byte;
            end
            S_STATUS: begin
               err_nxt   = 1'b0;
               state_nxt = S_DONE;
            end
            S_FLAGS: begin
               flags_nxt = rx_byte[NUM_FLAGS-1:0];
               state_nxt = S_DONE;
            end
            S_DONE: tx_nxt = 8'h00;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge SCLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         bit_cnt   <= 3'd0;
         rx_sr     <= 8'h00;
         tx_sr     <= 8'h00;
         addr      <= 16'd0;
         is_read   <= 1'b0;
         err       <= 1'b0;
         flags_out <= '0;
         wr_pulse  <= 1'b0;
         // NOTE: the memory is clearable flops, not a RAM macro, since the core sees every byte after reset.
         for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= 8'h00;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= SS ? 3'd0 : bit_cnt + 3'd1;
         rx_sr     <= rx_byte;
         tx_sr     <= tx_nxt;
         addr      <= addr_nxt;
         is_read   <= is_read_nxt;
         err       <= err_nxt;
         flags_out <= flags_nxt;
         wr_pulse  <= mem_we;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (mem_we && (addr == 16'(k))) mem[k] <= rx_byte;
         end
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_flat
      assign all_data_out[8*k +: 8] = mem[k];
   end

   assign MISO = tx_sr[7];
   assign busy = (state != S_IDLE) || (bit_cnt != 3'd0);

endmodule

// File: tb/tb_spi_burst_interface.sv
// Self-checking bench for spi_burst_interface: a byte-level frame model is
// compared against the DUT every cycle, plus literal checks of the test plan.
module tb_spi_burst_interface;

   localparam int DEPTH     = 80;
   localparam int NUM_FLAGS = 3;
   localparam int W         = DEPTH * 8;

   logic                  SCLK  = 1'b0;
   logic                  RESET = 1'b1;
   logic                  SS    = 1'b1;
   logic                  MOSI  = 1'b0;
   logic                  MISO;
   logic [W-1:0]          all_data_out;
   logic [NUM_FLAGS-1:0]  flags_out;
   logic                  wr_pulse;
   logic                  busy;

   spi_burst_interface #(.DEPTH(DEPTH), .NUM_FLAGS(NUM_FLAGS)) dut (
      .SCLK         (SCLK),
      .RESET        (RESET),
      .SS           (SS),
      .MOSI         (MOSI),
      .MISO         (MISO),
      .all_data_out (all_data_out),
      .flags_out    (flags_out),
      .wr_pulse     (wr_pulse),
      .busy         (busy)
   );

   always #5 SCLK = ~SCLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_mem(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Frame-level model: what the master has sent so far and what each byte means.
   logic [7:0]  m_mem [DEPTH];
   logic [2:0]  m_flags;
   logic        m_err;
   logic [15:0] m_addr;
   logic [7:0]  m_op, m_cur, m_tx;
   int          m_bit, m_idx, m_total;
   logic        m_wr;
   logic        cmp_en = 1'b0;
   int          pulse_cnt = 0;

   function automatic logic [7:0] m_read(input logic [15:0] a);
      return (a < DEPTH) ? m_mem[a] : 8'h00;
   endfunction

   function automatic logic [15:0] m_next(input logic [15:0] a);
      return (a == DEPTH - 1) ? 16'd0 : a + 16'd1;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
      m_flags = '0; m_err = 1'b0; m_addr = '0; m_op = '0; m_cur = '0; m_tx = '0;
      m_bit = 0; m_idx = 0; m_total = 0; m_wr = 1'b0;
   endtask

   task automatic m_byte(input logic [7:0] b);
      if (m_idx == 0) begin
         m_op = b;
         case (b)
            8'h02, 8'h03, 8'h06: ;
            8'h05:   m_tx = {m_err, 4'b0000, m_flags};
            default: m_err = 1'b1;
         endcase
      end else begin
         case (m_op)
            8'h02, 8'h03: begin
               if (m_idx == 1) m_addr[15:8] = b;
               else if (m_idx == 2) begin
                  m_addr[7:0] = b;
                  if (m_op == 8'h03) m_tx = m_read(m_addr);
               end else if (m_op == 8'h02) begin
                  if (m_addr < DEPTH) begin
                     m_mem[m_addr] = b;
                     m_wr = 1'b1;
                  end
                  m_addr = m_next(m_addr);
               end else begin
                  m_addr = m_next(m_addr);
                  m_tx   = m_read(m_addr);
               end
            end
            8'h05:   if (m_idx == 1) m_err = 1'b0;
            8'h06:   if (m_idx == 1) m_flags = b[2:0];
            default: ;
         endcase
      end
   endtask

   task automatic m_edge(input logic ss, input logic mosi);
      m_wr = 1'b0;
      if (ss) begin
         m_bit = 0; m_idx = 0; m_total = 0; m_tx = 8'h00;
      end else begin
         m_cur = {m_cur[6:0], mosi};
         m_tx  = {m_tx[6:0], 1'b0};
         m_bit++;
         m_total++;
         if (m_bit == 8) begin
            m_bit = 0;
            m_byte(m_cur);
            m_idx++;
         end
      end
   endtask

   // Compare process: outputs are registered, so the falling edge sees settled values.
   always @(negedge SCLK) begin
      if (cmp_en) begin
         logic [W-1:0] exp_flat;
         for (int k = 0; k < DEPTH; k++) exp_flat[8*k +: 8] = m_mem[k];
         check_mem("mem", all_data_out, exp_flat);
         check("flags", 32'(flags_out), 32'(m_flags));
         check("wr_pulse", 32'(wr_pulse), 32'(m_wr));
         check("miso", 32'(MISO), 32'(m_tx[7]));
         check("busy", 32'(busy), 32'(m_total != 0));
         if (wr_pulse) pulse_cnt++;
      end
   end

   task automatic tick(input logic rst, input logic ss, input logic mosi, output logic miso_s);
      @(negedge SCLK);
      #1;
      RESET  = rst;
      SS     = ss;
      MOSI   = mosi;
      miso_s = MISO;
      @(posedge SCLK);
      if (rst) m_reset();
      else     m_edge(ss, mosi);
      cmp_en = 1'b1;
   endtask

   logic [7:0] fq[$];
   logic [7:0] rq[$];

   task automatic frame(input bit close);
      logic [7:0] r;
      logic       b;
      rq.delete();
      foreach (fq[i]) begin
         r = 8'h00;
         for (int j = 7; j >= 0; j--) begin
            tick(1'b0, 1'b0, fq[i][j], b);
            r = {r[6:0], b};
         end
         rq.push_back(r);
      end
      if (close) tick(1'b0, 1'b1, 1'b0, b);
   endtask

   task automatic bits(input logic [7:0] v, input int n);
      logic b;
      for (int j = 7; j > 7 - n; j--) tick(1'b0, 1'b0, v[j], b);
   endtask

   initial begin
      logic         b;
      logic [W-1:0] ev;

      tick(1'b1, 1'b1, 1'b0, b);
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b0, 1'b1, 1'b0, b);
      check("rst_flags", 32'(flags_out), 32'h0);
      check_mem("rst_mem", all_data_out, '0);
      check("rst_miso", 32'(MISO), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);

      fq = '{8'h06, 8'h05};
      frame(1'b1);
      check("setflags", 32'(flags_out), 32'h5);
      check_mem("setflags_mem", all_data_out, '0);

      pulse_cnt = 0;
      fq = '{8'h02, 8'h00, 8'h04, 8'hAA, 8'hBB};
      frame(1'b1);
      check("burst_pulses", 32'(pulse_cnt), 32'd2);
      check("mem4", 32'(all_data_out[39:32]), 32'hAA);
      check("mem5", 32'(all_data_out[47:40]), 32'hBB);
      fq = '{8'h03, 8'h00, 8'h04, 8'h00, 8'h00};
      frame(1'b1);
      check("read4", 32'(rq[3]), 32'hAA);
      check("read5", 32'(rq[4]), 32'hBB);

      fq = '{8'h02, 8'h00, 8'h4F, 8'h11, 8'h22, 8'h33};
      frame(1'b1);
      check("wrap79", 32'(all_data_out[8*79 +: 8]), 32'h11);
      check("wrap0", 32'(all_data_out[7:0]), 32'h22);
      check("wrap1", 32'(all_data_out[15:8]), 32'h33);

      pulse_cnt = 0;
      fq = '{8'h02, 8'h01, 8'h00, 8'h77};
      frame(1'b1);
      ev = '0;
      ev[8*4 +: 8]  = 8'hAA;
      ev[8*5 +: 8]  = 8'hBB;
      ev[8*79 +: 8] = 8'h11;
      ev[8*0 +: 8]  = 8'h22;
      ev[8*1 +: 8]  = 8'h33;
      check_mem("oob_write_mem", all_data_out, ev);
      check("oob_pulses", 32'(pulse_cnt), 32'd0);
      fq = '{8'h03, 8'h01, 8'h00, 8'h00};
      frame(1'b1);
      check("oob_read", 32'(rq[3]), 32'h00);

      fq = '{8'h09, 8'h00};
      frame(1'b1);
      fq = '{8'h05, 8'h00};
      frame(1'b1);
      check("status_err", 32'(rq[1]), 32'h85);
      frame(1'b1);
      check("status_clr", 32'(rq[1]), 32'h05);

      fq = '{8'h02, 8'h00, 8'h10};
      frame(1'b0);
      bits(8'hCC, 4);
      tick(1'b0, 1'b1, 1'b0, b);
      check("partial_ss", 32'(all_data_out[8*16 +: 8]), 32'h00);
      check_mem("partial_ss_mem", all_data_out, ev);

      fq = '{8'h02, 8'h00, 8'h20, 8'h5A};
      frame(1'b0);
      bits(8'hC3, 5);
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b0, 1'b1, 1'b0, b);
      check_mem("mid_reset_mem", all_data_out, '0);
      check("mid_reset_flags", 32'(flags_out), 32'h0);
      fq = '{8'h06, 8'h02};
      frame(1'b1);
      check("clean_setflags", 32'(flags_out), 32'h2);
      fq = '{8'h05, 8'h00};
      frame(1'b1);
      check("clean_status", 32'(rq[1]), 32'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_burst_interface.md
# spi_burst_interface

Parametrised successor to the single-byte SPI configuration interface. It is an SPI-mode-0 slave that owns a DEPTH-byte configuration memory, with 16-bit addressing, auto-incrementing burst reads and writes, a status byte and a generic ready-flag register. It sits between the external SPI master and the SNN core. The core reads configuration from the flattened `all_data_out` and the ready handshake from `flags_out`.

## Interface
- DEPTH, 80: number of 8-bit memory locations (1..65535).
- NUM_FLAGS, 3: width of the ready-flag register (1..7).
- SCLK  in  1  SPI clock and the only clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset; needs ≥1 SCLK rising edge while high.
- SS  in  1  active-low slave select; sampled synchronously on SCLK.
- MOSI  in  1  serial data in, MSB first, sampled on SCLK rising edge.
- MISO  out  1  serial data out, MSB of the tx shift register; 0 when not transmitting.
- all_data_out  out  DEPTH*8  flattened memory; byte k at [8k+7:8k].
- flags_out  out  NUM_FLAGS  ready flags for the core.
- wr_pulse  out  1  high for one SCLK cycle after each committed memory write.
- busy  out  1  high while a frame is in progress (FSM not IDLE or bit count ≠ 0).

## Operation
- One clock (SCLK); reset is synchronous and active-high.
- Reset clears: memory to 0x00, flags_out 0, address 0, FSM to IDLE, bit counter 0, tx register 0, err 0, wr_pulse 0. MISO and busy therefore reset to 0.
- A rising edge with SS=1 acts as a frame reset: FSM→IDLE, bit counter 0, tx 0. Memory, flags and err are kept. The master must give ≥1 SCLK edge with SS high between frames.
- Bytes are assembled in an 8-bit rx shift register. A byte is complete on the edge where bit count = 7; the counter then wraps to 0.
- Byte 0 of a frame is the opcode:
  - 0x02 WRITE: ADDR_H → ADDR_L → WRITE_DATA.
  - 0x03 READ: ADDR_H → ADDR_L → READ_DATA.
  - 0x05 STATUS: → STATUS.
  - 0x06 SETFLAGS: → FLAGS.
  - Any other opcode sets sticky err and goes to DONE.
- ADDR_H / ADDR_L load addr[15:8] / addr[7:0].
- WRITE_DATA:
  - Each completed byte writes mem[addr] if addr < DEPTH; otherwise the byte is discarded and wr_pulse stays low.
  - addr then advances. Increment rule: addr = DEPTH-1 wraps to 0; addr ≥ DEPTH increments modulo 2^16 with no effect.
  - Remain in WRITE_DATA until SS rises.
- READ_DATA:
  - On the edge completing ADDR_L, tx loads mem[addr], or 0x00 if addr ≥ DEPTH.
  - On each completed data byte, addr advances and tx loads the byte at the new address.
  - MOSI content is ignored.
- STATUS: on the edge completing the opcode, tx loads {err, 7'b0 | flags_out}. Once that status byte has been fully shifted out, err clears and the FSM goes to DONE.
- FLAGS: the completed byte's low NUM_FLAGS bits load flags_out; FSM goes to DONE.
- DONE: ignores MOSI, MISO 0, until the frame reset.
- The tx register shifts left by one on every rising edge inside a transmitting byte. MISO = tx[7].

## Timing
- MISO changes just after a rising edge and is stable for the master's next rising-edge sample. Read data bit 7 appears after the 24th edge of a READ frame.
- A memory write and its all_data_out update take effect at the 8th edge of the data byte; the new value is visible immediately after that edge.
- wr_pulse is registered: high for exactly the cycle following that edge.
- flags_out updates at the 16th edge of a SETFLAGS frame.
- RESET has priority over SS. A RESET asserted mid-frame aborts the frame; a partially shifted byte is never written.
- Simultaneous byte completion and SS=1 on the same edge: SS wins, and the byte is discarded.
- Wrap-around: a 3-byte burst starting at DEPTH-1 writes DEPTH-1, 0, 1.

## Test plan
- Reset then SETFLAGS 0x06,0x05 → flags_out=3'b101 after edge 16; all_data_out all zero.
- WRITE 0x02,0x00,0x04,0xAA,0xBB → mem[4]=0xAA, mem[5]=0xBB; two one-cycle wr_pulse; then READ 0x03,0x00,0x04 + 2 dummy bytes → MISO returns 0xAA,0xBB.
- DEPTH=80: WRITE at 0x004F with 0x11,0x22,0x33 → mem[79]=0x11, mem[0]=0x22, mem[1]=0x33.
- WRITE at 0x0100 with 0x77 → memory unchanged, no wr_pulse; READ at 0x0100 → 0x00.
- Opcode 0x09, then frame reset, then STATUS → returns 0x80|flags; a second STATUS → bit7=0.
- SS raised after 4 bits of a data byte, and RESET asserted mid-burst → no partial write; next frame decodes cleanly from opcode.
